// File: rtl/if_id_stage_pkg.sv
// Shared fetch-side constants and types for the PC register, hazard unit and IF/ID stage.
package if_id_stage_pkg;

  localparam int unsigned XLEN = 32;

  // Bubble word used for squashed or not-yet-valid slots
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  // Reset value of the PC register
  localparam logic [XLEN-1:0] PC_INIT = 32'h0040_0000;

  // Next-PC source select, agreed between the hazard unit and the PC register
  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'b00,
    PCSRC_JUMP   = 2'b01,
    PCSRC_JUMPR  = 2'b10,
    PCSRC_BRANCH = 2'b11
  } pcsrc_e;

  // IF/ID register payload
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_stage_fetch_tracker.sv
// Tracks which PC the synchronous ROM word belongs to and whether it is on the correct path.
module fetch_tracker
  import if_id_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic [XLEN-1:0] pc_f,
  output logic            fetch_valid
);

  // ROM samples its address every edge, so the tag follows PC unconditionally
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_f        <= '0;
      fetch_valid <= 1'b0;
    end else begin
      pc_f        <= pc;
      fetch_valid <= ~flush;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch and IF/ID pipeline register with stall, flush and delivery counting.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_WORD,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      PC,
  output logic [31:0]      Instr_Mem_Addr,
  input  logic [31:0]      Instr_Mem_Data,
  input  logic             IF_ID_Write,
  input  logic             IF_ID_Flush,
  output logic [31:0]      Instruction_ID,
  output logic [31:0]      PC_ID,
  output logic [31:0]      PC_Plus_4_ID,
  output logic             Valid_ID,
  output logic             Misaligned_ID,
  output logic [CNT_W-1:0] Delivered_Count
);

  logic [XLEN-1:0]  pc_f;
  logic             fetch_valid;
  if_id_t           if_id_q;
  logic [CNT_W-1:0] count_q;

  assign Instr_Mem_Addr = PC;

  fetch_tracker u_fetch_tracker (
    .clk         (clk),
    .reset       (reset),
    .pc          (PC),
    .flush       (IF_ID_Flush),
    .pc_f        (pc_f),
    .fetch_valid (fetch_valid)
  );

  // IF/ID register and delivery counter: reset > flush > stall > capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_id_q <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
      count_q <= '0;
    end else if (IF_ID_Flush) begin
      if_id_q <= '{instr: NOP_INSTR, pc: pc_f, valid: 1'b0};
    end else if (IF_ID_Write) begin
      if_id_q <= '{instr: (fetch_valid ? Instr_Mem_Data : NOP_INSTR),
                   pc:    pc_f,
                   valid: fetch_valid};
      if (fetch_valid) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign Instruction_ID  = if_id_q.instr;
  assign PC_ID           = if_id_q.pc;
  assign Valid_ID        = if_id_q.valid;
  assign Delivered_Count = count_q;

  // Derived decode-side views of the captured PC
  assign PC_Plus_4_ID  = if_id_q.pc + 32'd4;
  assign Misaligned_ID = if_id_q.valid & (|if_id_q.pc[1:0]);

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with a slot-level reference model and literal pins.
module tb_if_id_stage;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   PC;
  logic [31:0]   Instr_Mem_Addr;
  logic [31:0]   Instr_Mem_Data;
  logic          IF_ID_Write;
  logic          IF_ID_Flush;
  logic [31:0]   Instruction_ID;
  logic [31:0]   PC_ID;
  logic [31:0]   PC_Plus_4_ID;
  logic          Valid_ID;
  logic          Misaligned_ID;
  logic [CW-1:0] Delivered_Count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference state: what decode must be seeing, and what the ROM has in flight
  logic [31:0]   m_fetch_pc;
  bit            m_fetch_ok;
  logic [31:0]   m_instr;
  logic [31:0]   m_pc;
  bit            m_valid;
  int            m_delivered;

  if_id_stage #(.NOP_INSTR(32'h0000_0000), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .PC              (PC),
    .Instr_Mem_Addr  (Instr_Mem_Addr),
    .Instr_Mem_Data  (Instr_Mem_Data),
    .IF_ID_Write     (IF_ID_Write),
    .IF_ID_Flush     (IF_ID_Flush),
    .Instruction_ID  (Instruction_ID),
    .PC_ID           (PC_ID),
    .PC_Plus_4_ID    (PC_Plus_4_ID),
    .Valid_ID        (Valid_ID),
    .Misaligned_ID   (Misaligned_ID),
    .Delivered_Count (Delivered_Count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  // Synchronous ROM: registers the address every edge
  always @(posedge clk) Instr_Mem_Data <= rom(Instr_Mem_Addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference by the stage's rules, settle
  task automatic step(input logic [31:0] pc, input bit wr, input bit fl, input bit rst_n);
    logic [31:0] n_fetch_pc, n_instr, n_pc;
    bit          n_fetch_ok, n_valid;
    int          n_deliv;
    PC = pc; IF_ID_Write = wr; IF_ID_Flush = fl; reset = rst_n;
    n_fetch_pc = m_fetch_pc; n_fetch_ok = m_fetch_ok;
    n_instr = m_instr; n_pc = m_pc; n_valid = m_valid; n_deliv = m_delivered;
    if (!rst_n) begin
      n_fetch_pc = 0; n_fetch_ok = 0; n_instr = 0; n_pc = 0; n_valid = 0; n_deliv = 0;
    end else begin
      n_fetch_pc = pc;
      n_fetch_ok = !fl;
      if (fl) begin
        n_instr = 0; n_valid = 0; n_pc = m_fetch_pc;
      end else if (wr) begin
        n_pc    = m_fetch_pc;
        n_valid = m_fetch_ok;
        n_instr = m_fetch_ok ? rom(m_fetch_pc) : 32'h0;
        if (m_fetch_ok) n_deliv = (m_delivered + 1) % (1 << CW);
      end
    end
    @(posedge clk);
    m_fetch_pc = n_fetch_pc; m_fetch_ok = n_fetch_ok;
    m_instr = n_instr; m_pc = n_pc; m_valid = n_valid; m_delivered = n_deliv;
    chk_en = 1'b1;
    #1;
  endtask

  // Every-cycle comparison against the reference
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_addr",  Instr_Mem_Addr, PC);
      check("instr_id",  Instruction_ID, m_instr);
      check("pc_id",     PC_ID, m_pc);
      check("pc4_id",    PC_Plus_4_ID, m_pc + 32'd4);
      check("valid_id",  32'(Valid_ID), 32'(m_valid));
      check("misalign",  32'(Misaligned_ID), 32'(m_valid && (m_pc[1:0] != 2'b00)));
      check("count",     32'(Delivered_Count), 32'(m_delivered));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_fetch_pc = 0; m_fetch_ok = 0; m_instr = 0; m_pc = 0; m_valid = 0; m_delivered = 0;
    PC = 32'h0040_0000; IF_ID_Write = 1'b1; IF_ID_Flush = 1'b0; reset = 1'b0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      step(32'h0040_0000, 1'b1, 1'b0, 1'b0);
      check("lit_rst_valid", 32'(Valid_ID), 32'd0);
      check("lit_rst_instr", Instruction_ID, 32'h0);
      check("lit_rst_count", 32'(Delivered_Count), 32'd0);
    end

    // Straight-line run from PC_INIT; first valid word lands on the 2nd edge
    for (int k = 0; k <= 8; k++) begin
      step(32'h0040_0000 + 32'(4 * k), 1'b1, 1'b0, 1'b1);
      if (k == 0) check("lit_first_edge_valid", 32'(Valid_ID), 32'd0);
      if (k == 1) begin
        check("lit_first_instr", Instruction_ID, 32'h2008_0005);
        check("lit_first_pc",    PC_ID, 32'h0040_0000);
        check("lit_first_pc4",   PC_Plus_4_ID, 32'h0040_0004);
        check("lit_first_valid", 32'(Valid_ID), 32'd1);
      end
    end
    check("lit_run_count", 32'(Delivered_Count), 32'd8);
    check("lit_run_pc",    PC_ID, 32'h0040_001C);

    // Stall three cycles with PC held
    for (int i = 0; i < 3; i++) begin
      step(32'h0040_0020, 1'b0, 1'b0, 1'b1);
      check("lit_stall_pc",    PC_ID, 32'h0040_001C);
      check("lit_stall_count", 32'(Delivered_Count), 32'd8);
    end
    step(32'h0040_0024, 1'b1, 1'b0, 1'b1);
    check("lit_unstall_pc",    PC_ID, 32'h0040_0020);
    check("lit_unstall_count", 32'(Delivered_Count), 32'd9);
    step(32'h0040_0028, 1'b1, 1'b0, 1'b1);
    check("lit_after_stall_pc", PC_ID, 32'h0040_0024);

    // One-cycle flush, jump target 0x0040_0100
    step(32'h0040_002C, 1'b1, 1'b1, 1'b1);
    check("lit_flush_slot1", 32'(Valid_ID), 32'd0);
    check("lit_flush_nop1",  Instruction_ID, 32'h0);
    step(32'h0040_0100, 1'b1, 1'b0, 1'b1);
    check("lit_flush_slot2", 32'(Valid_ID), 32'd0);
    step(32'h0040_0104, 1'b1, 1'b0, 1'b1);
    check("lit_jump_pc",    PC_ID, 32'h0040_0100);
    check("lit_jump_valid", 32'(Valid_ID), 32'd1);

    // Flush and stall together: bubble, not hold
    step(32'h0040_0108, 1'b0, 1'b1, 1'b1);
    check("lit_flushstall_valid", 32'(Valid_ID), 32'd0);
    step(32'h0040_010C, 1'b1, 1'b0, 1'b1);
    step(32'h0040_0110, 1'b1, 1'b0, 1'b1);
    check("lit_refill_pc", PC_ID, 32'h0040_010C);

    // Misaligned fetch address
    step(32'h0040_0002, 1'b1, 1'b0, 1'b1);
    step(32'h0040_0008, 1'b1, 1'b0, 1'b1);
    check("lit_misaligned", 32'(Misaligned_ID), 32'd1);
    check("lit_mis_count",  32'(Delivered_Count), 32'd14);

    // PC wrap and 4-bit counter wrap (16th delivery returns to 0)
    step(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1);
    step(32'h0000_0000, 1'b1, 1'b0, 1'b1);
    check("lit_pc_top",     PC_ID, 32'hFFFF_FFFC);
    check("lit_pc4_wrap",   PC_Plus_4_ID, 32'h0);
    check("lit_count_wrap", 32'(Delivered_Count), 32'd0);

    // Stall while fetch slot is invalid: hold, then the held PC is delivered
    step(32'h0040_0200, 1'b1, 1'b1, 1'b1);
    step(32'h0040_0204, 1'b0, 1'b0, 1'b1);
    step(32'h0040_0208, 1'b1, 1'b0, 1'b1);
    check("lit_stall_inv_pc", PC_ID, 32'h0040_0204);

    // Reset asserted mid-stall, then mid-flush
    step(32'h0040_0300, 1'b0, 1'b0, 1'b1);
    step(32'h0040_0300, 1'b0, 1'b0, 1'b0);
    check("lit_rst_mid_valid", 32'(Valid_ID), 32'd0);
    step(32'h0040_0300, 1'b1, 1'b1, 1'b0);
    check("lit_rst_mid_count", 32'(Delivered_Count), 32'd0);
    step(32'h0040_0000, 1'b1, 1'b0, 1'b1);
    step(32'h0040_0004, 1'b1, 1'b0, 1'b1);
    check("lit_rerelease_instr", Instruction_ID, 32'h2008_0005);
    step(32'h0040_0008, 1'b1, 1'b0, 1'b1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch / IF-ID pipeline stage sitting directly downstream of the PC register. It drives the PC value to the synchronous instruction ROM and tracks which PC each ROM word belongs to. It captures fetched words into the IF/ID register with stall and flush control, so decode always sees a correctly paired {instruction, PC, PC+4, valid}. It also flags misaligned fetch addresses and counts instructions delivered to decode.

## Interface
Parameters:
- NOP_INSTR, 32'h0000_0000: instruction word inserted for bubbles.
- CNT_W, 32: width of the delivered-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low (0 = reset).
- PC  input  32  current PC-register value (the address being fetched this cycle).
- Instr_Mem_Addr  output  32  ROM address; combinationally equal to PC.
- Instr_Mem_Data  input  32  ROM read data.
  - ROM registers its address at posedge, so data in cycle k belongs to the PC of cycle k-1.
- IF_ID_Write  input  1  0 = stall: IF/ID register holds its contents.
- IF_ID_Flush  input  1  1 = squash: kills the capture at this edge and the in-flight fetch.
- Instruction_ID  output  32  instruction presented to decode.
- PC_ID  output  32  PC of Instruction_ID.
- PC_Plus_4_ID  output  32  PC_ID + 4.
- Valid_ID  output  1  Instruction_ID is a real, correct-path instruction.
- Misaligned_ID  output  1  PC_ID[1:0] != 0 and Valid_ID.
- Delivered_Count  output  CNT_W  number of valid instructions captured into IF/ID.

## Operation
Fetch tracker (internal registers):
- pc_f: PC of the word currently on Instr_Mem_Data.
- fetch_valid: that word is on the correct path.
- Every non-reset edge:
  - pc_f <= PC (the ROM samples every cycle, stalled or not).
  - fetch_valid <= ~IF_ID_Flush.

IF/ID register, priority reset > flush > stall > capture:
- Reset: Instruction_ID = NOP_INSTR, PC_ID = 0, Valid_ID = 0, Delivered_Count = 0, pc_f = 0, fetch_valid = 0.
- Flush: Instruction_ID <= NOP_INSTR, Valid_ID <= 0. PC_ID is don't-care; it is loaded with pc_f.
- Stall (IF_ID_Write = 0, no flush): all IF/ID outputs hold.
- Capture (normal cycle):
  - Instruction_ID <= fetch_valid ? Instr_Mem_Data : NOP_INSTR.
  - PC_ID <= pc_f.
  - Valid_ID <= fetch_valid.

Derived outputs:
- PC_Plus_4_ID is combinational from PC_ID, 32-bit modulo (0xFFFF_FFFC + 4 = 0).
- Misaligned_ID is combinational; it never asserts when Valid_ID = 0.

Delivered_Count:
- Increments by 1 on each capture edge where fetch_valid = 1 and there is no flush or stall.
- Wraps modulo 2^CNT_W.

Boundary behaviour:
- Flush while stalled: flush wins; the bubble is inserted.
- Stall while fetch_valid = 0: IF/ID holds; fetch_valid becomes 1 at the edge, because the ROM re-reads the held, correct-path PC.
- Reset mid-stall or mid-flush: reset wins; after release, the first valid capture occurs two edges after the first non-reset edge.

## Timing
- Latency, PC value to Valid_ID: 2 edges (ROM edge, then IF/ID edge).
- Flush squashes exactly two slots: the word captured at the flush edge and the word in flight in the ROM.
  - Covers jump resolved in ID and branch resolved in EX; the ID/EX flush is outside this block.
- No handshake: upstream PC_Write and IF_ID_Write are driven together by the hazard unit; this block does not check their consistency.
- All outputs are registered except Instr_Mem_Addr, PC_Plus_4_ID and Misaligned_ID.

## Structure
Shared package holds:
- NOP_INSTR.
- PC_INIT (32'h0040_0000), shared with the PC register.
- PCSrc encodings (00 PC+4, 01 Jump, 10 JumpR, 11 Branch), so the hazard unit and PC agree.

Sub-module: fetch_tracker (pc_f, fetch_valid) is the natural split. The IF/ID register and counter stay in the top.

## Test plan
- Reset sequencing:
  - Stimulus: hold reset = 0 for 3 cycles with PC = 0x0040_0000, ROM[0x0040_0000] = 0x2008_0005.
  - Response: during reset, Valid_ID = 0, Instruction_ID = 0, Delivered_Count = 0. After release, Valid_ID = 1 with Instruction_ID = 0x2008_0005, PC_ID = 0x0040_0000, PC_Plus_4_ID = 0x0040_0004 on the 2nd edge.
- Straight-line run:
  - Stimulus: PC increments by 4 for 8 cycles.
  - Response: PC_ID follows the PC sequence delayed 2 cycles; Delivered_Count = 8 after the 8th valid capture.
- Stall for 3 cycles:
  - Stimulus: IF_ID_Write = 0 and PC held.
  - Response: outputs frozen; on release the next instruction is the one at the held PC, with no duplicate and no loss; the counter does not advance during the stall.
- Flush for a jump to 0x0040_0100:
  - Stimulus: one-cycle IF_ID_Flush.
  - Response: two consecutive Valid_ID = 0 slots with NOP; then PC_ID = 0x0040_0100, Valid_ID = 1.
- Flush and stall asserted together:
  - Response: bubble inserted (Valid_ID = 0), not a hold.
- Boundaries:
  - PC = 0x0040_0002 → Misaligned_ID = 1 when captured.
  - PC_ID = 0xFFFF_FFFC → PC_Plus_4_ID = 0.
  - Counter preset near 2^CNT_W−1 via run (reduce CNT_W to 4) → wraps to 0.
